// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
//   Shared definitions for the convolution front end: default datapath
//   sizes and the feeder FSM state encoding.
// ---------------------------------------------------------------------------
package conv_pkg;

  // Strip height; must match the stride row mapper's input count.
  localparam int NUM_ROWS   = 13;
  // Pixel width.
  localparam int DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage : conv_pkg

// File: rtl/row_bank.sv
// ---------------------------------------------------------------------------
// row_bank
//   Storage for one row of an input-feature-map strip.
//   One synchronous write port and one asynchronous read port.
//
// Ports:
//   clk    in   clock, write on rising edge
//   we     in   write enable
//   waddr  in   write column
//   wdata  in   write pixel
//   raddr  in   read column
//   rdata  out  pixel at raddr (combinational)
// ---------------------------------------------------------------------------
module row_bank #(
  parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
  parameter int DEPTH      = 32,
  parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset branch on purpose; its contents are only
  // meaningful after a full LOAD, and a reset would force flops instead of RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : row_bank

// File: rtl/ifmap_row_feeder.sv
// ---------------------------------------------------------------------------
// ifmap_row_feeder
//   Buffers a NUM_ROWS x W strip of pixels arriving row-major, then replays
//   it one column per handshake on NUM_ROWS parallel row outputs feeding the
//   stride row mapper.
//
// Ports:
//   clk, rst_n            clock / synchronous active-low reset
//   start, cfg_cols       begin a strip of cfg_cols columns (IDLE only)
//   in_valid/in_ready     pixel input handshake, in_data pixel
//   out_valid/out_ready   column output handshake
//   dataout_1..13         pixel of rows 0..12 at the presented column
//   out_col, out_last     presented column index / last-column flag
//   busy                  not IDLE
//   done                  one-cycle pulse after the last column handshake
//   cfg_err               one-cycle pulse when a start is rejected
// ---------------------------------------------------------------------------
module ifmap_row_feeder #(
  parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
  parameter int NUM_ROWS   = conv_pkg::NUM_ROWS,
  parameter int IMG_W      = 32,
  parameter int COL_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [COL_W-1:0]      cfg_cols,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] dataout_1,
  output logic [DATA_WIDTH-1:0] dataout_2,
  output logic [DATA_WIDTH-1:0] dataout_3,
  output logic [DATA_WIDTH-1:0] dataout_4,
  output logic [DATA_WIDTH-1:0] dataout_5,
  output logic [DATA_WIDTH-1:0] dataout_6,
  output logic [DATA_WIDTH-1:0] dataout_7,
  output logic [DATA_WIDTH-1:0] dataout_8,
  output logic [DATA_WIDTH-1:0] dataout_9,
  output logic [DATA_WIDTH-1:0] dataout_10,
  output logic [DATA_WIDTH-1:0] dataout_11,
  output logic [DATA_WIDTH-1:0] dataout_12,
  output logic [DATA_WIDTH-1:0] dataout_13,
  output logic [COL_W-1:0]      out_col,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  import conv_pkg::*;

  localparam int                AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int                ROW_W    = $clog2(NUM_ROWS);
  localparam logic [COL_W-1:0]  MAX_COLS = COL_W'(IMG_W);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(NUM_ROWS - 1);

  state_t                state, state_next;

  logic [COL_W-1:0]      w_cols;     // latched strip width
  logic [COL_W-1:0]      wr_col;
  logic [ROW_W-1:0]      wr_row;
  logic [COL_W-1:0]      rd_col;

  logic [DATA_WIDTH-1:0] bank_rdata [NUM_ROWS];
  logic [DATA_WIDTH-1:0] col_reg    [NUM_ROWS];

  logic                  cfg_ok;
  logic                  start_ok;
  logic                  wr_fire;
  logic                  wr_col_last;
  logic                  last_pixel;
  logic                  rd_col_last;
  logic                  col_load;
  logic                  last_hs;

  // -------------------------------------------------------------------------
  // Control decode
  // -------------------------------------------------------------------------
  assign cfg_ok      = (cfg_cols != '0) && (cfg_cols <= MAX_COLS);
  assign start_ok    = (state == IDLE) && start && cfg_ok;
  assign wr_fire     = (state == LOAD) && in_valid;
  assign wr_col_last = (wr_col == w_cols - COL_W'(1));
  assign last_pixel  = wr_fire && wr_col_last && (wr_row == LAST_ROW);
  assign rd_col_last = (rd_col == w_cols - COL_W'(1));
  assign last_hs     = out_valid && out_ready && out_last;

  // Refill the output register when it is empty or being consumed, unless the
  // column it holds is already the last one (nothing remains to read).
  assign col_load    = (state == DRAIN) && (!out_valid || out_ready) &&
                       !(out_valid && out_last);

  assign in_ready    = (state == LOAD);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: the default at the top means every path assigns state_next, so no
  // latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok)   state_next = LOAD;
      LOAD:    if (last_pixel) state_next = DRAIN;
      DRAIN:   if (last_hs)    state_next = DONE;
      DONE:                    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Write / read counters
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_cols <= '0;
      wr_col <= '0;
      wr_row <= '0;
      rd_col <= '0;
    end else if (start_ok) begin
      w_cols <= cfg_cols;
      wr_col <= '0;
      wr_row <= '0;
      rd_col <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_col_last) begin
          wr_col <= '0;
          wr_row <= wr_row + ROW_W'(1);
        end else begin
          wr_col <= wr_col + COL_W'(1);
        end
      end
      // rd_col parks on W-1; out_last then blocks further loads.
      if (col_load && !rd_col_last) begin
        rd_col <= rd_col + COL_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Row banks
  // -------------------------------------------------------------------------
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_bank
    row_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_W),
      .AW         (AW)
    ) u_row_bank (
      .clk   (clk),
      .we    (wr_fire && (wr_row == ROW_W'(r))),
      .waddr (wr_col[AW-1:0]),
      .wdata (in_data),
      .raddr (rd_col[AW-1:0]),
      .rdata (bank_rdata[r])
    );
  end

  // -------------------------------------------------------------------------
  // Output register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_col   <= '0;
      for (int r = 0; r < NUM_ROWS; r++) begin
        col_reg[r] <= '0;
      end
    end else if (col_load) begin
      out_valid <= 1'b1;
      out_last  <= rd_col_last;
      out_col   <= rd_col;
      for (int r = 0; r < NUM_ROWS; r++) begin
        col_reg[r] <= bank_rdata[r];
      end
    end else if (last_hs) begin
      // Pixel outputs and out_col keep the last column.
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= (state == IDLE) && start && !cfg_ok;
    end
  end

  // Flat port mapping for the row mapper's 13 inputs.
  assign dataout_1  = col_reg[0];
  assign dataout_2  = col_reg[1];
  assign dataout_3  = col_reg[2];
  assign dataout_4  = col_reg[3];
  assign dataout_5  = col_reg[4];
  assign dataout_6  = col_reg[5];
  assign dataout_7  = col_reg[6];
  assign dataout_8  = col_reg[7];
  assign dataout_9  = col_reg[8];
  assign dataout_10 = col_reg[9];
  assign dataout_11 = col_reg[10];
  assign dataout_12 = col_reg[11];
  assign dataout_13 = col_reg[12];

endmodule : ifmap_row_feeder

// File: tb/tb_ifmap_row_feeder.sv
// ---------------------------------------------------------------------------
// tb_ifmap_row_feeder
//   Directed sequence of strips with randomized pixels and handshakes,
//   checked against a strip array model: column c of a strip must present
//   pix[row][c] on every row output.
// ---------------------------------------------------------------------------
module tb_ifmap_row_feeder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  cfg_cols;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dataout_1, dataout_2, dataout_3, dataout_4, dataout_5;
  logic [15:0] dataout_6, dataout_7, dataout_8, dataout_9, dataout_10;
  logic [15:0] dataout_11, dataout_12, dataout_13;
  logic [5:0]  out_col;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        cfg_err;

  logic [15:0] dout [13];
  logic [15:0] pix  [13][32];

  int errors = 0;
  int checks = 0;

  ifmap_row_feeder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_cols   (cfg_cols),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .dataout_1  (dataout_1),
    .dataout_2  (dataout_2),
    .dataout_3  (dataout_3),
    .dataout_4  (dataout_4),
    .dataout_5  (dataout_5),
    .dataout_6  (dataout_6),
    .dataout_7  (dataout_7),
    .dataout_8  (dataout_8),
    .dataout_9  (dataout_9),
    .dataout_10 (dataout_10),
    .dataout_11 (dataout_11),
    .dataout_12 (dataout_12),
    .dataout_13 (dataout_13),
    .out_col    (out_col),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  assign dout[0]  = dataout_1;
  assign dout[1]  = dataout_2;
  assign dout[2]  = dataout_3;
  assign dout[3]  = dataout_4;
  assign dout[4]  = dataout_5;
  assign dout[5]  = dataout_6;
  assign dout[6]  = dataout_7;
  assign dout[7]  = dataout_8;
  assign dout[8]  = dataout_9;
  assign dout[9]  = dataout_10;
  assign dout[10] = dataout_11;
  assign dout[11] = dataout_12;
  assign dout[12] = dataout_13;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string t);
    check({t, "_in_ready"},  32'(in_ready),  0);
    check({t, "_out_valid"}, 32'(out_valid), 0);
    check({t, "_out_last"},  32'(out_last),  0);
    check({t, "_busy"},      32'(busy),      0);
    check({t, "_done"},      32'(done),      0);
    check({t, "_cfg_err"},   32'(cfg_err),   0);
    check({t, "_out_col"},   32'(out_col),   0);
    for (int k = 0; k < 13; k++) begin
      check($sformatf("%s_dataout_%0d", t, k + 1), 32'(dout[k]), 0);
    end
  endtask

  // Reference strip: either row*16+col or random pixels.
  task automatic fill_pix(input int w, input bit pattern);
    for (int r = 0; r < 13; r++) begin
      for (int c = 0; c < w; c++) begin
        pix[r][c] = pattern ? 16'(r * 16 + c) : 16'($urandom);
      end
    end
  endtask

  task automatic good_start(input int w);
    start    = 1'b1;
    cfg_cols = 6'(w);
    step();
    start    = 1'b0;
    check("start_busy",     32'(busy),     1);
    check("start_in_ready", 32'(in_ready), 1);
    check("start_no_err",   32'(cfg_err),  0);
  endtask

  task automatic bad_start(input int w);
    start    = 1'b1;
    cfg_cols = 6'(w);
    step();
    start    = 1'b0;
    check($sformatf("cfg_err_pulse_w%0d", w), 32'(cfg_err), 1);
    check($sformatf("cfg_err_busy_w%0d", w),  32'(busy),    0);
    step();
    check($sformatf("cfg_err_clear_w%0d", w), 32'(cfg_err), 0);
    check($sformatf("cfg_err_idle_w%0d", w),  32'(busy),    0);
  endtask

  // Streams the reference strip row-major; optionally pokes a start with
  // cfg_cols=5 in the middle of LOAD, which must have no effect.
  task automatic load_strip(input int w, input int vpct, input bit poke);
    int  idx   = 0;
    int  cyc   = 0;
    int  total = 13 * w;
    bit  rdy;
    while (idx < total && cyc < 20000) begin
      in_valid = ($urandom_range(99) < vpct);
      in_data  = pix[idx / w][idx % w];
      if (poke) begin
        start    = (cyc == 7);
        cfg_cols = (cyc == 7) ? 6'd5 : 6'(w);
      end
      rdy = in_ready;
      step();
      cyc++;
      if (in_valid && rdy) idx++;
      if (poke && cyc == 8) check("poke_no_cfg_err", 32'(cfg_err), 0);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check($sformatf("load_count_w%0d", w), 32'(idx),       32'(total));
    check("load_in_ready_low",             32'(in_ready),  0);
    check("load_out_valid_low",            32'(out_valid), 0);
    check("load_busy",                     32'(busy),      1);
  endtask

  // Consumes columns with out_ready asserted rpct% of cycles; each presented
  // column is compared with the model, so a stalled column must stay put.
  task automatic drain_strip(input int w, input int rpct, input bit check_tp);
    int e     = 0;
    int cyc   = 0;
    int first = -1;
    bit hs;
    while (e < w && cyc < 20000) begin
      out_ready = ($urandom_range(99) < rpct);
      if (out_valid) begin
        if (first < 0) first = cyc;
        check($sformatf("col_idx_e%0d", e),  32'(out_col),  32'(e));
        check($sformatf("col_last_e%0d", e), 32'(out_last), 32'(e == w - 1));
        for (int k = 0; k < 13; k++) begin
          check($sformatf("w%0d_col%0d_row%0d", w, e, k), 32'(dout[k]), 32'(pix[k][e]));
        end
      end
      hs = out_valid && out_ready;
      step();
      cyc++;
      if (hs) e++;
    end
    out_ready = 1'b0;
    check($sformatf("drain_cols_w%0d", w), 32'(e),     32'(w));
    check("first_col_latency",             32'(first), 1);
    if (check_tp) check($sformatf("drain_cycles_w%0d", w), 32'(cyc), 32'(w + 1));
    check("done_pulse",      32'(done),      1);
    check("valid_after_end", 32'(out_valid), 0);
    check("busy_in_done",    32'(busy),      1);
    step();
    check("done_low",        32'(done),      0);
    check("busy_low",        32'(busy),      0);
  endtask

  initial begin
    int cyc;
    rst_n     = 1'b0;
    start     = 1'b0;
    cfg_cols  = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    step();

    // Rejected widths.
    bad_start(0);
    bad_start(33);

    // Basic strip, W=4, pixel = row*16+col, full-rate handshakes.
    fill_pix(4, 1'b1);
    good_start(4);
    load_strip(4, 100, 1'b0);
    drain_strip(4, 100, 1'b1);

    // Backpressure and input gaps, W=8.
    fill_pix(8, 1'b0);
    good_start(8);
    load_strip(8, 50, 1'b0);
    drain_strip(8, 50, 1'b0);

    // Single-column strip.
    fill_pix(1, 1'b1);
    good_start(1);
    load_strip(1, 100, 1'b0);
    check("w1_row13_value", 32'(pix[12][0]), 32'h00C0);
    drain_strip(1, 70, 1'b0);

    // Maximum width.
    fill_pix(32, 1'b0);
    good_start(32);
    load_strip(32, 80, 1'b0);
    drain_strip(32, 100, 1'b1);

    // Reset while column 3 of a W=8 strip is presented.
    fill_pix(8, 1'b0);
    good_start(8);
    load_strip(8, 100, 1'b0);
    out_ready = 1'b1;
    cyc = 0;
    while (!(out_valid && out_col == 6'd3) && cyc < 100) begin
      step();
      cyc++;
    end
    check("rst_reached_col3", 32'(out_col), 3);
    rst_n     = 1'b0;
    out_ready = 1'b0;
    step();
    check_reset("rst_mid_drain");
    rst_n = 1'b1;
    step();

    // Fresh strip after the abandoned one.
    fill_pix(5, 1'b0);
    good_start(5);
    load_strip(5, 60, 1'b0);
    drain_strip(5, 60, 1'b0);

    // Start pulse with cfg_cols=5 during LOAD of a W=4 strip is ignored.
    fill_pix(4, 1'b0);
    good_start(4);
    load_strip(4, 100, 1'b1);
    drain_strip(4, 100, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ifmap_row_feeder

// File: doc/ifmap_row_feeder.md
# ifmap_row_feeder

Input-feature-map feeder directly upstream of the stride row mapper.
- Buffers a 13-row × up-to-IMG_W-column strip of pixels, arriving as a row-major stream.
- Then replays the strip one column per handshake on 13 parallel row outputs `dataout_1`..`dataout_13`.
- Those outputs drive the row mapper's 13 inputs, which fan out to the 5×5 PE array.
- 13 rows cover a 5×5 window at stride 1 or 2 (5 output rows × stride 2 + 3).

## Interface
Parameters:
- `DATA_WIDTH`, 16, pixel width.
- `NUM_ROWS`, 13, strip height; fixed; must equal the row mapper input count.
- `IMG_W`, 32, maximum strip width in columns.
- `COL_W`, 6, width of column fields; holds 0..IMG_W.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a strip; sampled in IDLE only.
- `cfg_cols`  in  COL_W  strip width; latched on an accepted start; legal range 1..IMG_W.
- `in_valid`  in  1  input pixel valid.
- `in_ready`  out  1  feeder accepts a pixel.
- `in_data`  in  DATA_WIDTH  pixel, row-major order (row 0 cols 0..W-1, then row 1, …).
- `out_valid`  out  1  column on the `dataout_*` outputs is valid.
- `out_ready`  in  1  downstream (PE array) consumes the column.
- `dataout_1`..`dataout_13`  out  DATA_WIDTH each  pixel of rows 0..12 at the current column.
- `out_col`  out  COL_W  index of the presented column.
- `out_last`  out  1  presented column is cols-1.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse after the last column handshake.
- `cfg_err`  out  1  one-cycle pulse when a start is rejected.

## Operation
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE, `start`=1 with 1≤`cfg_cols`≤IMG_W:
  - latch W, clear row/col counters, go to LOAD.
  - Out-of-range `cfg_cols` (0 or >IMG_W): stay IDLE, pulse `cfg_err` the next cycle.
- `start` outside IDLE is ignored; no error.
- LOAD: `in_ready`=1.
  - Each `in_valid`&&`in_ready` writes `in_data` to bank[row][col], then increments col.
  - col wraps at W-1 and increments row.
  - Acceptance of (row 12, col W-1) moves to DRAIN; `in_ready`=0 from that next cycle.
  - `in_valid` gaps simply stall the counters.
- DRAIN: one-stage output register, loaded from bank[*][rd_col] when `out_valid`=0 or `out_ready`=1, while columns remain.
  - `out_valid`, `dataout_*` and `out_col` change only on such a load.
  - The column is held stable while `out_valid`&&!`out_ready`.
- Handshake of the column with `out_last`=1: next cycle `out_valid`=0 and state DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `dataout_*` hold their last value after DRAIN.
- Storage is not cleared by reset or start; contents are only valid after LOAD.
- All counters are unsigned. rd_col runs 0..W-1 with no wrap beyond W-1.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`, `out_valid`, `out_last`, `busy`, `done`, `cfg_err` = 0.
  - `out_col` = 0; all `dataout_*` = 0.
- Sync reset at any time, including mid-LOAD or mid-DRAIN: the next edge gives the reset values; the partial strip is abandoned.
- `start` accepted at edge T: `busy`=1 and `in_ready`=1 from T+1.
- Last pixel accepted at edge T:
  - T+1: state DRAIN, column 0 loaded.
  - T+2: `out_valid`=1 with column 0.
- Fill-to-first-column latency is 2 cycles.
- Throughput: one column per cycle when `out_ready` is held high; W columns take W cycles.
- Last handshake at edge T:
  - T+1: `done`=1, `out_valid`=0.
  - T+2: `busy`=0; `start` may be accepted at the T+2 edge.
- W=1: column 0 is read after the write of row 12 completes, so there is no read/write hazard (it uses the same 2-cycle path).

## Structure
- Shared package `conv_pkg` holds:
  - `NUM_ROWS`=13 and `DATA_WIDTH`=16 defaults.
  - the FSM state enum (IDLE/LOAD/DRAIN/DONE, 2-bit).
- Sub-module `row_bank`, instantiated NUM_ROWS times:
  - IMG_W×DATA_WIDTH storage.
  - one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
  - Write enable is decoded from the row counter.
- Top holds the FSM, counters, output register and flat `dataout_*` port mapping.

## Test plan
- Basic strip: W=4, pixel = row*16+col.
  - Column c gives `dataout_k` = (k-1)*16+c.
  - `out_last` only at c=3; `done` 1 cycle after the c=3 handshake; `busy` low after.
- Backpressure and gaps: W=8, `out_ready` random 50%, `in_valid` random 50%.
  - Every column appears exactly once, in order, and held stable while stalled.
  - Accepted input count = 104.
- Edge widths:
  - W=1: one column with `dataout_13`=0xC0.
  - W=32 (IMG_W): 416 pixels in, 32 columns out.
  - `cfg_cols`=0 or 33: `cfg_err` pulse, `busy` stays 0.
- Reset mid-operation: `rst_n` low at column 3 of DRAIN, W=8.
  - Next cycle: all outputs equal the reset values.
  - A new strip then runs correctly.
- Start while busy: pulse `start` with `cfg_cols`=5 during LOAD (W=4).
  - Ignored: still exactly 52 pixels accepted, and 4 columns out.
